// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults for the 640x480@60 timer and its axis counters.
// Counters are CNT_W bits wide, so any axis total must stay at or below 1024.
package vga_timing_pkg;

    localparam int CNT_W  = 10;
    localparam int FCNT_W = 16;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int visible, input int fp);
        return visible + fp;
    endfunction

endpackage

// File: rtl/vga_timer_if.sv
// Raster timing bundle: the timer drives it (master), pixel generators read it (slave).
interface vga_timer_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0]  h_counter;
    logic [CNT_W-1:0]  v_counter;
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic              pix_tick;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    // No handshake: every field is a registered, mutually aligned level or one-clock strobe.
    modport master (
        output h_counter, v_counter, hsync, vsync, video_on,
        output pix_tick, line_start, frame_start, frame_count
    );

    modport slave (
        input h_counter, v_counter, hsync, vsync, video_on,
        input pix_tick, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered active and sync flags,
// all derived from the next-state count so they line up with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int SYNC_START = sync_start(DEF_H_VISIBLE, DEF_H_FP),
    parameter int SYNC_END   = sync_start(DEF_H_VISIBLE, DEF_H_FP) + DEF_H_SYNC
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync_n
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    // One extra bit so a boundary equal to 1024 still compares correctly.
    localparam logic [CNT_W:0]   VIS_C   = (CNT_W + 1)'(VISIBLE);
    localparam logic [CNT_W:0]   SYNC_LO = (CNT_W + 1)'(SYNC_START);
    localparam logic [CNT_W:0]   SYNC_HI = (CNT_W + 1)'(SYNC_END);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_ext;
    logic             active_q;
    logic             active_d;
    logic             sync_n_q;
    logic             sync_n_d;

    assign wrap = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_comb begin
        count_ext = {1'b0, count_d};
        active_d  = (count_ext < VIS_C);
        sync_n_d  = !((count_ext >= SYNC_LO) && (count_ext < SYNC_HI));
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timer.sv
// Master raster timing generator: pixel-enable divider, horizontal and vertical axis
// counters, sync/video outputs, per-line/per-frame strobes and a wrapping frame counter.
module vga_timer
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 1,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        clk,
    input  logic        clear_n,
    vga_timer_if.master vga
);

    localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = sync_start(H_VISIBLE, H_FP);
    localparam int V_SYNC_START = sync_start(V_VISIBLE, V_FP);
    localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]  div_cnt_q;
    logic [DIV_W-1:0]  div_cnt_d;
    logic              pe;
    logic              h_wrap;
    logic              v_wrap;
    logic              v_en;
    logic [CNT_W-1:0]  h_count;
    logic [CNT_W-1:0]  v_count;
    logic              h_active;
    logic              v_active;
    logic              h_sync_n;
    logic              v_sync_n;
    logic              pix_tick_q;
    logic              line_start_q;
    logic              frame_start_q;
    logic [FCNT_W-1:0] frame_count_q;
    logic [FCNT_W-1:0] frame_count_d;

    // The first pixel enable lands on the CLK_DIV-th edge after reset release.
    assign pe = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = pe ? '0 : div_cnt_q + DIV_W'(1);
    end

    assign v_en = pe && h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_START + H_SYNC)
    ) u_h_axis (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (pe),
        .count   (h_count),
        .wrap    (h_wrap),
        .active  (h_active),
        .sync_n  (h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_START + V_SYNC)
    ) u_v_axis (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (v_en),
        .count   (v_count),
        .wrap    (v_wrap),
        .active  (v_active),
        .sync_n  (v_sync_n)
    );

    // v_wrap already implies pe and h_wrap, so it marks the clock entering (0,0).
    always_comb begin
        frame_count_d = v_wrap ? frame_count_q + FCNT_W'(1) : frame_count_q;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            div_cnt_q     <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_tick_q    <= pe;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.h_counter   = h_count;
    assign vga.v_counter   = v_count;
    assign vga.hsync       = h_sync_n;
    assign vga.vsync       = v_sync_n;
    assign vga.video_on    = h_active && v_active;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timer.sv
// Bench for vga_timer: full-size timing at CLK_DIV=1 and 4, plus a shrunken raster
// (16x11 totals) so whole frames and the frame counter wrap fit in a short run.
module tb_vga_timer;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic clear_n_a;
    logic clear_n_s;
    logic clear_n_d;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    vga_timer_if if_a ();
    vga_timer_if if_s ();
    vga_timer_if if_d ();

    vga_timer #(.CLK_DIV(1)) dut_a (
        .clk     (clk),
        .clear_n (clear_n_a),
        .vga     (if_a)
    );

    vga_timer #(
        .CLK_DIV(1),
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk     (clk),
        .clear_n (clear_n_s),
        .vga     (if_s)
    );

    vga_timer #(.CLK_DIV(4)) dut_d (
        .clk     (clk),
        .clear_n (clear_n_d),
        .vga     (if_d)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        check_eq("rst_h", if_a.h_counter, 799);
        check_eq("rst_v", if_a.v_counter, 524);
        check_eq("rst_hsync", if_a.hsync, 1);
        check_eq("rst_vsync", if_a.vsync, 1);
        check_eq("rst_video", if_a.video_on, 0);
        check_eq("rst_tick", if_a.pix_tick, 0);
        check_eq("rst_ls", if_a.line_start, 0);
        check_eq("rst_fs", if_a.frame_start, 0);
        check_eq("rst_fc", if_a.frame_count, 0);
        check_eq("rst_d_h", if_d.h_counter, 799);
    endtask

    task automatic test_line();
        int hs_low = 0, vid_on = 0, ls_cnt = 0, seq_err = 0;
        int hs_first = -1, hs_last = -1;
        clear_n_a = 1'b1;
        tick();
        check_eq("first_h", if_a.h_counter, 0);
        check_eq("first_v", if_a.v_counter, 0);
        check_eq("first_video", if_a.video_on, 1);
        check_eq("first_fs", if_a.frame_start, 1);
        check_eq("first_ls", if_a.line_start, 1);
        check_eq("first_fc", if_a.frame_count, 1);
        check_eq("first_tick", if_a.pix_tick, 1);
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            if (if_a.h_counter !== 10'(i)) seq_err++;
            if (!if_a.hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (if_a.video_on) vid_on++;
            if (if_a.line_start) ls_cnt++;
        end
        check_eq("h_seq", seq_err, 0);
        check_eq("hsync_low", hs_low, 96);
        check_eq("hsync_first", hs_first, 656);
        check_eq("hsync_last", hs_last, 751);
        check_eq("video_cnt", vid_on, 640);
        check_eq("ls_in_line", ls_cnt, 1);
        tick();
        check_eq("l1_h", if_a.h_counter, 0);
        check_eq("l1_v", if_a.v_counter, 1);
        check_eq("l1_ls", if_a.line_start, 1);
        check_eq("l1_fs", if_a.frame_start, 0);
    endtask

    task automatic test_mid_reset();
        tick_n(300);
        check_eq("mid_h", if_a.h_counter, 300);
        check_eq("mid_v", if_a.v_counter, 1);
        clear_n_a = 1'b0;
        #1;
        check_eq("async_h", if_a.h_counter, 799);
        check_eq("async_v", if_a.v_counter, 524);
        check_eq("async_video", if_a.video_on, 0);
        check_eq("async_hsync", if_a.hsync, 1);
        check_eq("async_tick", if_a.pix_tick, 0);
        check_eq("async_fc", if_a.frame_count, 0);
        tick();
        clear_n_a = 1'b1;
        tick();
        check_eq("rel_h", if_a.h_counter, 0);
        check_eq("rel_v", if_a.v_counter, 0);
        check_eq("rel_fs", if_a.frame_start, 1);
        check_eq("rel_fc", if_a.frame_count, 1);
    endtask

    task automatic test_frames();
        int fs_cnt = 0, last_fs = 0, vs_low = 0, vs_first = -1, got = 0;
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd3);
        clear_n_s = 1'b1;
        for (int i = 0; i <= 352; i++) begin
            tick();
            if (if_s.frame_start) begin
                fs_cnt++;
                if (exp_q.size() > 0) check_eq("fs_count", if_s.frame_count, exp_q.pop_front());
                if (fs_cnt > 1) check_eq("fs_period", i - last_fs, 176);
                last_fs = i;
            end
            if (i < 176 && !if_s.vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
            if (i == 175) begin
                check_eq("end_h", if_s.h_counter, 15);
                check_eq("end_v", if_s.v_counter, 10);
            end
            if (i == 176) begin
                check_eq("wrap_h", if_s.h_counter, 0);
                check_eq("wrap_v", if_s.v_counter, 0);
            end
        end
        check_eq("fs_total", fs_cnt, 3);
        check_eq("fs_left", exp_q.size(), 0);
        check_eq("vsync_low", vs_low, 32);
        check_eq("vsync_first", vs_first, 112);
        tick();
        force dut_s.frame_count_q = 16'hFFFF;
        tick();
        release dut_s.frame_count_q;
        check_eq("fc_preload", if_s.frame_count, 16'hFFFF);
        for (int k = 0; k < 400 && got == 0; k++) begin
            tick();
            if (if_s.frame_start) got = 1;
        end
        check_eq("fc_wrap_seen", got, 1);
        check_eq("fc_wrap", if_s.frame_count, 0);
    endtask

    task automatic test_div4();
        int ticks = 0, tick_err = 0, hold_err = 0, ls_first = -1, ls_second = -1;
        logic [9:0] prev_h = 10'd799;
        clear_n_d = 1'b1;
        for (int e = 1; e <= 3204; e++) begin
            tick();
            if (e == 3) begin
                check_eq("d3_tick", if_d.pix_tick, 0);
                check_eq("d3_h", if_d.h_counter, 799);
            end
            if (e == 4) begin
                check_eq("d4_tick", if_d.pix_tick, 1);
                check_eq("d4_h", if_d.h_counter, 0);
                check_eq("d4_fs", if_d.frame_start, 1);
            end
            if (e == 5) begin
                check_eq("d5_tick", if_d.pix_tick, 0);
                check_eq("d5_h", if_d.h_counter, 0);
                check_eq("d5_fs", if_d.frame_start, 0);
            end
            if (if_d.pix_tick) begin
                ticks++;
                if (e % 4 != 0) tick_err++;
            end
            if (if_d.h_counter != prev_h && !if_d.pix_tick) hold_err++;
            prev_h = if_d.h_counter;
            if (if_d.line_start) begin
                if (ls_first < 0) ls_first = e;
                else if (ls_second < 0) ls_second = e;
            end
        end
        check_eq("d_ticks", ticks, 801);
        check_eq("d_tick_phase", tick_err, 0);
        check_eq("d_hold", hold_err, 0);
        check_eq("d_ls_first", ls_first, 4);
        check_eq("d_ls_second", ls_second, 3204);
    endtask

    initial begin
        clear_n_a = 1'b0;
        clear_n_s = 1'b0;
        clear_n_d = 1'b0;
        tick_n(3);
        test_reset();
        test_line();
        test_mid_reset();
        test_frames();
        test_div4();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
